// File: rtl/polo_transmitter.sv
// polo_transmitter: answers each detector match pulse by sending "POLO"
// (8N1, LSB first) on the UART tx line, queuing up to MAX_PENDING extra
// requests that arrive while a message is in flight.
// Build option: define POLO_CRLF_EN to append CR/LF (6-byte message).
module polo_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned MAX_PENDING  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic tx,
  output logic busy,
  output logic msg_done,
  output logic dropped
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
`ifdef POLO_CRLF_EN
  localparam int unsigned NUM_BYTES = 6;
`else
  localparam int unsigned NUM_BYTES = 4;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_BYTES - 1);
  localparam logic [1:0]       PEND_MAX = 2'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [2:0]       r_idx;
  logic [1:0]       r_pend;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_drop;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [2:0]       w_bit_nx;
  logic [2:0]       w_idx_nx;
  logic [1:0]       w_pend_nx;
  logic             w_tx_nx;
  logic             w_busy_nx;
  logic             w_done_nx;
  logic             w_drop_nx;
  logic [7:0]       w_byte;
  logic             w_wrap;
  logic             w_msg_end;

  // Message ROM
  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_byte = 8'h50;
      3'd1:    rom_byte = 8'h4F;
      3'd2:    rom_byte = 8'h4C;
      3'd3:    rom_byte = 8'h4F;
`ifdef POLO_CRLF_EN
      3'd4:    rom_byte = 8'h0D;
      3'd5:    rom_byte = 8'h0A;
`endif
      default: rom_byte = 8'hFF;
    endcase
  endfunction

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign w_msg_end = (r_state == STOP) && w_wrap && (r_idx == LAST_IDX);

  // Next-state, queue bookkeeping and next values of the registered outputs
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_idx_nx   = r_idx;
    w_pend_nx  = r_pend;
    w_drop_nx  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (trigger) begin
          w_state_nx = START;
          w_idx_nx   = 3'd0;
        end
      end
      START: begin
        w_cnt_nx = w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap) begin
          w_state_nx = DATA;
          w_bit_nx   = 3'd0;
        end
      end
      DATA: begin
        w_cnt_nx = w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap) begin
          if (r_bit == 3'd7) w_state_nx = STOP;
          else               w_bit_nx   = r_bit + 3'd1;
        end
      end
      STOP: begin
        w_cnt_nx = w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap) begin
          if (r_idx != LAST_IDX) begin
            w_idx_nx   = r_idx + 3'd1;
            w_state_nx = START;
          end else if (trigger) begin
            // coincident trigger is counted and consumed by the restart at once
            w_idx_nx   = 3'd0;
            w_state_nx = START;
          end else if (r_pend != 2'd0) begin
            w_pend_nx  = r_pend - 2'd1;
            w_idx_nx   = 3'd0;
            w_state_nx = START;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase

    if ((r_state != IDLE) && trigger && !w_msg_end) begin
      if (r_pend < PEND_MAX) w_pend_nx = r_pend + 2'd1;
      else                   w_drop_nx = 1'b1;
    end

    w_byte    = rom_byte(w_idx_nx);
    w_tx_nx   = 1'b1;
    if (w_state_nx == START)     w_tx_nx = 1'b0;
    else if (w_state_nx == DATA) w_tx_nx = w_byte[w_bit_nx];
    w_busy_nx = (w_state_nx != IDLE);
    w_done_nx = (w_state_nx == STOP) && (w_cnt_nx == CNT_LAST) && (w_idx_nx == LAST_IDX);
  end

  // State and output registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_idx   <= 3'd0;
      r_pend  <= 2'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_idx   <= w_idx_nx;
      r_pend  <= w_pend_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_drop  <= w_drop_nx;
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign msg_done = r_done;
  assign dropped  = r_drop;

endmodule

// File: tb/tb_polo_transmitter.sv
// Bench for polo_transmitter with CLKS_PER_BIT=4, MAX_PENDING=1.
module tb_polo_transmitter;

`ifdef POLO_CRLF_EN
  localparam int NB = 6;
`else
  localparam int NB = 4;
`endif
  localparam int CPB  = 4;
  localparam int MSGL = NB * 10 * CPB;
  localparam int MAXP = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic trigger;
  logic tx, busy, msg_done, dropped;

  polo_transmitter #(.CLKS_PER_BIT(CPB), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger),
    .tx(tx), .busy(busy), .msg_done(msg_done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  logic [7:0] msg_rom [6] = '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: message offset arithmetic plus a pending count
  bit m_active = 0;
  int m_off    = 0;
  int m_pend   = 0;
  bit m_drop   = 0;

  function automatic logic frame_bit(input int off);
    int b, s;
    logic [7:0] v;
    b = off / (10 * CPB);
    s = (off % (10 * CPB)) / CPB;
    v = msg_rom[b];
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return v[s-1];
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_off = 0; m_pend = 0; m_drop = 0;
    end else begin
      m_drop = 0;
      if (!m_active) begin
        if (trigger) begin m_active = 1; m_off = 0; end
      end else if (m_off == MSGL - 1) begin
        if (trigger)          m_off = 0;
        else if (m_pend > 0) begin m_pend--; m_off = 0; end
        else                  m_active = 0;
      end else begin
        m_off++;
        if (trigger) begin
          if (m_pend < MAXP) m_pend++;
          else               m_drop = 1;
        end
      end
    end
  end

  // Per-cycle compare plus event trackers and a UART byte decoder
  int   done_q[$];
  int   fall_q[$];
  int   rx_q[$];
  int   drop_cnt  = 0;
  int   first_low = -1;
  int   run = 0, max_run = 0;
  bit   prev_busy = 0;
  bit   in_frame  = 0;
  int   fs = 0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; run = 0; prev_busy = 0;
    end else begin
      check("tx",       tx,       m_active ? frame_bit(m_off) : 1'b1);
      check("busy",     busy,     m_active);
      check("msg_done", msg_done, m_active && (m_off == MSGL - 1));
      check("dropped",  dropped,  m_drop);
      if (msg_done) done_q.push_back(cyc);
      if (dropped) drop_cnt++;
      if (tx == 1'b0 && first_low < 0) first_low = cyc;
      if (busy) begin run++; if (run > max_run) max_run = run; end
      else run = 0;
      if (prev_busy && !busy) fall_q.push_back(cyc);
      prev_busy = busy;
      if (!in_frame) begin
        if (tx == 1'b0) begin in_frame = 1; fs = cyc; end
      end else begin
        int rel;
        rel = cyc - fs;
        if (rel >= CPB + 1 && rel <= 8 * CPB + 1 && ((rel - CPB - 1) % CPB) == 0)
          sh[(rel - CPB - 1) / CPB] = tx;
        if (rel == 9 * CPB + 1) rx_q.push_back(int'(sh));
        if (rel == 10 * CPB - 1) in_frame = 0;
      end
    end
  end

  task automatic clear_trk();
    done_q.delete(); fall_q.delete(); rx_q.delete();
    drop_cnt = 0; first_low = -1; max_run = 0;
  endtask

  task automatic go_cycle(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(output int n);
    n = cyc;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(busy == 1'b0 && k > 2) && k <= budget) begin @(posedge clk); #1; k++; end
    if (k > budget) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: busy still high after %0d cycles", budget);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_bytes(input int nmsg);
    check("byte_count", rx_q.size(), nmsg * NB);
    for (int i = 0; i < rx_q.size() && i < nmsg * NB; i++)
      check($sformatf("byte%0d", i), rx_q[i], msg_rom[i % NB]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    rst_n   = 1'b0;
    trigger = 1'b0;
    #7;
    check("rst_tx", tx, 1); check("rst_busy", busy, 0);
    check("rst_done", msg_done, 0); check("rst_drop", dropped, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // idle after reset
    clear_trk();
    go_cycle(cyc + 100);
    check("idle_done_count", done_q.size(), 0);
    check("idle_drop_count", drop_cnt, 0);
    check("idle_first_low", first_low, -1);

    // single message
    clear_trk();
    pulse(n);
    wait_idle(MSGL + 20);
    check("single_start_cycle", first_low, n + 1);
    check("single_done_count", done_q.size(), 1);
    if (done_q.size() == 1) check("single_done_cycle", done_q[0], n + MSGL);
    if (fall_q.size() >= 1) check("single_busy_fall", fall_q[0], n + MSGL + 1);
    else check("single_busy_fall_seen", fall_q.size(), 1);
    check_bytes(1);

    // queued retrigger during byte 2
    clear_trk();
    pulse(n);
    go_cycle(n + 90);
    pulse(n2);
    wait_idle(2 * MSGL + 20);
    check("queue_done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("queue_done0", done_q[0], n + MSGL);
      check("queue_done1", done_q[1], n + 2 * MSGL);
    end
    check("queue_busy_run", max_run, 2 * MSGL);
    check("queue_drop_count", drop_cnt, 0);
    check_bytes(2);

    // overflow: third request dropped
    clear_trk();
    pulse(n);
    go_cycle(n + 20);
    pulse(n2);
    go_cycle(n + 60);
    pulse(n2);
    wait_idle(3 * MSGL);
    check("ovf_drop_count", drop_cnt, 1);
    check("ovf_done_count", done_q.size(), 2);
    check_bytes(2);

    // trigger coincident with msg_done while queue full
    clear_trk();
    pulse(n);
    go_cycle(n + 20);
    pulse(n2);
    go_cycle(n + MSGL);
    pulse(n2);
    wait_idle(4 * MSGL);
    check("coinc_drop_count", drop_cnt, 0);
    check("coinc_done_count", done_q.size(), 3);
    check("coinc_busy_run", max_run, 3 * MSGL);
    check_bytes(3);

    // reset mid-message while tx is low (data bit 4 of 'O')
    clear_trk();
    pulse(n);
    go_cycle(n + 62);
    check("pre_reset_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_busy", busy, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_trk();
    go_cycle(cyc + 30);
    check("post_reset_idle", first_low, -1);
    pulse(n);
    wait_idle(MSGL + 20);
    check("post_reset_done_count", done_q.size(), 1);
    if (done_q.size() == 1) check("post_reset_done_cycle", done_q[0], n + MSGL);
    check_bytes(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
